// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, flags.
// Imported by the ALU top and its multiplier sub-block.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_MUL  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    typedef struct packed {
        logic cout;
        logic zero;
        logic set;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/writeback handshake bundle for alu_seq.
// The issuing stage is the master, the ALU the slave.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             set;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result,
        input  cout, zero, set, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result,
        output cout, zero, set, overflow, busy
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done_o marks the final step; prod_o then carries the complete product.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;

    // Accumulator value after the current step
    assign prod_o = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o = run_q && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            acc_q    <= '0;
            mplier_q <= b_i;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= prod_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (done_o) begin
                cnt_q <= '0;
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU between register read and writeback, with a
// registered handshake on both sides and an optional iterative MUL.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    state_t state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    flags_t flags_q, flags_d;

    logic             sub_op;
    logic             is_mul;
    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             add_ovf;
    logic             slt;
    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign sub_op  = (bus.op == OP_SUB) || (bus.op == OP_SLT);
    assign is_mul  = MUL_EN && (bus.op == OP_MUL);
    assign bp      = sub_op ? ~bus.b : bus.b;
    assign {carry, sum} = {1'b0, bus.a} + {1'b0, bp}
                        + {{WIDTH{1'b0}}, sub_op};
    assign add_ovf = (bus.a[WIDTH-1] == bp[WIDTH-1])
                  && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    // Sign of the difference corrected by overflow gives a true signed compare
    assign slt     = sum[WIDTH-1] ^ add_ovf;

    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        unique case (1'b1)
            bus.op == OP_AND: alu_res = bus.a & bus.b;
            bus.op == OP_OR:  alu_res = bus.a | bus.b;
            bus.op == OP_ADD, bus.op == OP_SUB: begin
                alu_res            = sum;
                alu_flags.cout     = carry;
                alu_flags.overflow = add_ovf;
            end
            bus.op == OP_SLT: begin
                alu_res       = {{(WIDTH-1){1'b0}}, slt};
                alu_flags.set = slt;
            end
            default: alu_res = '0;
        endcase
        alu_flags.zero = (alu_res == '0);
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        flags_d   = flags_q;
        mul_start = 1'b0;
        unique case (1'b1)
            state_q == S_IDLE: begin
                if (bus.in_valid) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        res_d   = alu_res;
                        flags_d = alu_flags;
                        state_d = S_DONE;
                    end
                end
            end
            state_q == S_MUL: begin
                if (mul_done) begin
                    res_d            = mul_prod[WIDTH-1:0];
                    flags_d          = '0;
                    flags_d.zero     = (mul_prod[WIDTH-1:0] == '0);
                    flags_d.overflow = |mul_prod[2*WIDTH-1:WIDTH];
                    state_d          = S_DONE;
                end
            end
            state_q == S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    if (MUL_EN) begin : g_mul
        alu_mul_iter #(
            .WIDTH (WIDTH)
        ) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start_i (mul_start),
            .a_i     (bus.a),
            .b_i     (bus.b),
            .done_o  (mul_done),
            .prod_o  (mul_prod)
        );
    end else begin : g_nomul
        assign mul_done = 1'b0;
        assign mul_prod = '0;
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_MUL);
    assign bus.result    = res_q;
    assign bus.cout      = flags_q.cout;
    assign bus.zero      = flags_q.zero;
    assign bus.set       = flags_q.set;
    assign bus.overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an arithmetic model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus();

    alu_seq #(
        .WIDTH  (W),
        .MUL_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_op(
        input  logic [2:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] r,
        output logic        c,
        output logic        z,
        output logic        s,
        output logic        o
    );
        longint sa, sb, d;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; c = 1'b0; s = 1'b0; o = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: begin
                u = {32'd0, a} + {32'd0, b};
                r = u[31:0];
                c = u[32];
                d = sa + sb;
                o = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
            OP_SUB: begin
                r = a - b;
                c = (a >= b);
                d = sa - sb;
                o = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
            OP_SLT: begin
                s = (sa < sb);
                r = {31'd0, s};
            end
            OP_MUL: begin
                u = {32'd0, a} * {32'd0, b};
                r = u[31:0];
                o = (u[63:32] != 32'd0);
            end
            default: r = '0;
        endcase
        z = (r == 32'd0);
    endfunction

    task automatic check_out(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b);
        logic [31:0] r;
        logic c, z, s, o;
        ref_op(op, a, b, r, c, z, s, o);
        chk("result", 64'(bus.result), 64'(r));
        chk("cout", 64'(bus.cout), 64'(c));
        chk("zero", 64'(bus.zero), 64'(z));
        chk("set", 64'(bus.set), 64'(s));
        chk("overflow", 64'(bus.overflow), 64'(o));
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int lat;
        int nb;
        @(negedge clk);
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.op = 3'($urandom_range(0, 7));
        lat = 1;
        nb = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.busy) nb++;
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), (op == OP_MUL) ? 64'd33 : 64'd1);
        if (op == OP_MUL) chk("busy_cycles", 64'(nb), 64'd32);
        chk("in_ready_done", 64'(bus.in_ready), 64'd0);
        check_out(op, a, b);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.op = OP_AND;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_flags", 64'({bus.cout, bus.zero, bus.set, bus.overflow}), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        chk("add_ovf_dir", 64'(bus.overflow), 64'd1);
        run_op(OP_SUB, 32'd5, 32'd5);
        chk("sub_cout_dir", 64'(bus.cout), 64'd1);
        run_op(OP_SLT, 32'hFFFF_FFFD, 32'd2);
        chk("slt_neg_dir", 64'(bus.result), 64'd1);
        run_op(OP_SLT, 32'h8000_0000, 32'd1);
        chk("slt_min_dir", 64'(bus.set), 64'd1);
        run_op(OP_MUL, 32'd7, 32'd6);
        chk("mul_42_dir", 64'(bus.result), 64'd42);
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        chk("mul_hi_dir", 64'({bus.zero, bus.overflow}), 64'd3);
        run_op(3'b100, 32'hDEAD_BEEF, 32'h1234_5678);
        run_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
        run_op(OP_OR, 32'h0000_0000, 32'h0000_0000);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                ra = 32'($urandom_range(0, 15)) - 32'd8;
                rb = 32'($urandom_range(0, 15)) - 32'd8;
            end else begin
                ra = $urandom;
                rb = $urandom;
            end
            run_op(rop, ra, rb);
        end

        // Backpressure: result held, pending op waits for release
        @(negedge clk);
        chk("bp_ready", 64'(bus.in_ready), 64'd1);
        bus.op = OP_SUB;
        bus.a = 32'd100;
        bus.b = 32'd30;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.op = OP_OR;
        bus.a = 32'h0000_00F0;
        bus.b = 32'h0000_000F;
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_res0", 64'(bus.result), 64'd70);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_hold_res", 64'(bus.result), 64'd70);
            chk("bp_hold_cout", 64'(bus.cout), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_rel_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_next_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_next_res", 64'(bus.result), 64'h0000_00FF);

        // Reset in the middle of a multiply
        run_op(OP_ADD, 32'd3, 32'd4);
        @(negedge clk);
        bus.op = OP_MUL;
        bus.a = 32'd12345;
        bus.b = 32'd6789;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_mul_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_result", 64'(bus.result), 64'd0);
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_flags", 64'({bus.cout, bus.zero, bus.set, bus.overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        run_op(OP_ADD, 32'd1, 32'd1);
        chk("post_rst_add", 64'(bus.result), 64'd2);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the combinational 32-bit ALU. It adds a registered valid/ready handshake on both sides, a configurable datapath width, signed set-less-than, and an iterative unsigned multiply. It sits between the register-read stage and writeback. The issuing stage may stall on `in_ready`, and writeback may stall on `out_ready`.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4 and even.
- `MUL_EN`, default 1: 1 enables MUL; 0 makes op 011 behave as reserved.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: an operation is presented on `a`, `b`, `op`.
- `in_ready` out 1: block can accept an operation.
- `a` in WIDTH: operand A, two's complement.
- `b` in WIDTH: operand B, two's complement.
- `op` in 3: operation select (see Operation).
- `out_valid` out 1: result and flags are valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out WIDTH: operation result.
- `cout` out 1: adder carry-out (ADD/SUB only).
- `zero` out 1: `result` == 0.
- `set` out 1: signed a < b (SLT only).
- `overflow` out 1: signed ADD/SUB overflow, or MUL high half nonzero.
- `busy` out 1: a MUL iteration is in progress.

## Operation
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB (a + ~b + 1)
  - 111 SLT (result = {0…,set})
  - 011 MUL (unsigned a×b, low WIDTH bits)
  - 100 and 101 reserved: result 0, all flags 0 except `zero` = 1.
- An operation is accepted when `in_valid && in_ready`. Operands and op are captured at acceptance and ignored otherwise.
- FSM states: IDLE, MUL, DONE.
  - IDLE: `in_ready` = 1. On accept of a non-MUL op, compute and register `result` and flags, then go to DONE. On accept of MUL, load the multiplicand, multiplier and a zeroed 2×WIDTH accumulator, set the iteration counter to 0, and go to MUL.
  - MUL: one shift-add step per cycle, LSB first. The counter increments each cycle. After step WIDTH-1, register the low half as `result`, set `overflow` = |high half, and go to DONE. `in_ready` = 0 and `busy` = 1 throughout.
  - DONE: `out_valid` = 1 and `in_ready` = 0. On `out_ready` = 1, go to IDLE.
- Flag rules:
  - `cout` is the carry out of bit WIDTH-1 for ADD/SUB; for SUB, 1 means no borrow. It is 0 for all other ops.
  - `overflow` for ADD/SUB is (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the post-inversion operand.
  - `set` is (a −ₛ b) sign XOR subtract overflow, i.e. a correct signed compare. It is 0 for ops other than SLT.
  - `zero` is always computed from the registered `result`.
- Outputs are held stable while `out_valid` && !`out_ready`. They keep their last value in IDLE, and `out_valid` = 0 there.
- Reset (any state, including mid-MUL) aborts the operation. It drives IDLE, `out_valid` = 0, `result` = 0, all flags = 0, `busy` = 0, and the counter to 0. `in_ready` = 1 after deassertion.

## Timing
- Non-MUL latency: `out_valid` rises on the edge after acceptance (1 cycle).
- MUL latency: `out_valid` rises WIDTH+1 cycles after acceptance (33 for WIDTH = 32).
- Minimum issue interval is 2 cycles for non-MUL ops (IDLE → DONE → IDLE). There is no acceptance in DONE, even when `out_ready` = 1 in the same cycle.
- `in_ready` is a function of state only, with no combinational path from `in_valid` or `out_ready`. `out_valid` is likewise a function of state only.
- Counter width is clog2(WIDTH). Terminal count is WIDTH-1; the counter does not wrap into the next op.

## Structure
- Shared package `alu_pkg` holds:
  - op encoding constants (`OP_AND`, `OP_OR`, `OP_ADD`, `OP_MUL`, `OP_SUB`, `OP_SLT`);
  - the FSM state typedef (IDLE, MUL, DONE);
  - a flag struct {cout, zero, set, overflow}.
- One sub-module, `alu_mul_iter`, contains the multiplier registers, accumulator and counter. Its interface is start/done, and it is instantiated only when `MUL_EN` = 1.
- The adder/logic path is in-line combinational logic feeding the result register.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → `result` = 0x80000000, `overflow` = 1, `cout` = 0, `zero` = 0; `out_valid` 1 cycle after accept.
- SUB a=5, b=5 → `result` = 0, `zero` = 1, `cout` = 1, `overflow` = 0.
- SLT a=−3, b=2 → `result` = 1, `set` = 1. SLT a=0x80000000, b=1 → `set` = 1, despite subtract overflow.
- MUL 7×6 → `result` = 42, `overflow` = 0, `out_valid` exactly 33 cycles after accept, `busy` high for 32 cycles. MUL 0x10000×0x10000 → `result` = 0, `zero` = 1, `overflow` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE → `result` and flags stable, `in_ready` = 0 throughout, a pending `in_valid` is not accepted; accepted 1 cycle after release.
- Assert `rst_n` low during MUL step 10 → all outputs 0 immediately (asynchronous); after release, `in_ready` = 1 and a new ADD 1+1 returns 2.
